pipe_exec_reg: RTL and testbench
================================

PIPE_EXEC_REG -- requirements
Module: pipe_exec_reg

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- OP_W, 5, opcode width
- SCALAR_W, 32, scalar operand width
- IMM_W, 8, immediate width
- VEC_W, 128, vector operand width
- WB_W, 3, write-back register index width
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  stage enable; 0 = freeze
- flush  in  1  synchronous squash of all held entries
- d_valid  in  1  upstream entry valid
- d_ready  out  1  stage can accept
- d_opcode, d_reg1_data, d_reg2_data, d_immediate, d_vec1_data, d_vec2_data, d_wb_register  in  OP_W, SCALAR_W, SCALAR_W, IMM_W, VEC_W, VEC_W, WB_W  payload in
- q_valid  out  1  output entry valid
- q_ready  in  1  downstream accepts
- q_opcode, q_reg1_data, q_reg2_data, q_immediate, q_vec1_data, q_vec2_data, q_wb_register  out  same widths  payload out
- occupancy  out  2  held entries, 0..2
- stall_cnt  out  16  saturating back-pressure cycle count

Function
REQ-003 Storage SHALL be a main register driving q_* plus one skid register; no combinational path from d_* payload to q_* payload.
REQ-004 States SHALL be EMPTY (occupancy 0), FULL (1), SKID (2).
REQ-005 accept = d_valid & d_ready; transfer = q_valid & q_ready.
REQ-006 d_ready SHALL equal en & (state != SKID), with no dependence on q_ready.
REQ-007 q_valid SHALL equal en & (state != EMPTY); q_* SHALL always show main.
REQ-008 EMPTY: accept -> main <= d, FULL; else stay.
REQ-009 FULL: accept & transfer -> main <= d, stay FULL; accept only -> skid <= d, SKID; transfer only -> EMPTY; neither -> hold.
REQ-010 SKID: transfer -> main <= skid, FULL; else hold.
REQ-011 Latency SHALL be 1 cycle from accept into EMPTY/FULL-with-transfer until q_valid on that entry; entry order SHALL be preserved.
REQ-012 en=0 SHALL freeze state, main, skid and stall_cnt; no accept or transfer occurs.
REQ-013 flush=1 SHALL force EMPTY at the next edge, overriding accept, transfer and en=0; payload registers retain their values.
REQ-014 stall_cnt SHALL increment when q_valid & ~q_ready & ~flush, saturate at 16'hFFFF, and clear only on reset.
REQ-015 An accept in the same cycle as flush SHALL be discarded.

Reset
REQ-016 rst_n low SHALL asynchronously force EMPTY, all q_* payload, main and skid to 0, stall_cnt to 0; d_ready and q_valid SHALL read 0 while rst_n is low.
REQ-017 Reset assertion mid-transfer SHALL drop all held entries; first accept is possible on the first edge after rst_n rises with en=1.

Verification
REQ-018 en=1, q_ready=1, d_valid=1, opcode 8, reg1 5, reg2 15, imm 8, vec1 32, vec2 90, wb 3 -> next cycle q_valid=1 with those values, occupancy 1.
REQ-019 Holding that entry, q_ready=0, send opcode 12, reg1 7 -> occupancy 2, d_ready=0, q_* still opcode 8; raise q_ready -> opcode 8 then opcode 12 leave in order.
REQ-020 Entry held, en=0 for 5 cycles with d_valid=1 and new payload -> q_valid=0, d_ready=0, main unchanged, stall_cnt unchanged; en=1 -> original entry reappears.
REQ-021 occupancy 2 plus flush=1 with d_valid=1 -> next cycle occupancy 0, q_valid=0, d_ready=1, no entry delivered.
REQ-022 q_valid=1, q_ready=0 for 70000 cycles -> stall_cnt = 16'hFFFF and holds.
REQ-023 Assert rst_n low asynchronously at occupancy 2 between edges -> immediately q_valid=0, d_ready=0, q_* = 0, occupancy 0.

Source files
------------

// File: rtl/pipe_exec_reg.sv
// Execute-stage pipeline register with one skid slot.
// The main register always drives q_*. A second entry lands in the skid
// register when downstream stalls, so d_ready never depends on q_ready.
module pipe_exec_reg #(
    parameter int unsigned OP_W     = 5,
    parameter int unsigned SCALAR_W = 32,
    parameter int unsigned IMM_W    = 8,
    parameter int unsigned VEC_W    = 128,
    parameter int unsigned WB_W     = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic                d_valid,
    output logic                d_ready,
    input  logic [OP_W-1:0]     d_opcode,
    input  logic [SCALAR_W-1:0] d_reg1_data,
    input  logic [SCALAR_W-1:0] d_reg2_data,
    input  logic [IMM_W-1:0]    d_immediate,
    input  logic [VEC_W-1:0]    d_vec1_data,
    input  logic [VEC_W-1:0]    d_vec2_data,
    input  logic [WB_W-1:0]     d_wb_register,
    output logic                q_valid,
    input  logic                q_ready,
    output logic [OP_W-1:0]     q_opcode,
    output logic [SCALAR_W-1:0] q_reg1_data,
    output logic [SCALAR_W-1:0] q_reg2_data,
    output logic [IMM_W-1:0]    q_immediate,
    output logic [VEC_W-1:0]    q_vec1_data,
    output logic [VEC_W-1:0]    q_vec2_data,
    output logic [WB_W-1:0]     q_wb_register,
    output logic [1:0]          occupancy,
    output logic [15:0]         stall_cnt
);

    localparam int unsigned PL_W = OP_W + 2 * SCALAR_W + IMM_W + 2 * VEC_W + WB_W;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [PL_W-1:0] r_main;
    logic [PL_W-1:0] r_skid;
    logic [15:0]     r_stall_cnt;
    logic [PL_W-1:0] w_d_payload;
    logic            w_d_ready;
    logic            w_q_valid;
    logic            w_accept;
    logic            w_transfer;
    logic            w_ld_main_d;
    logic            w_ld_main_skid;
    logic            w_ld_skid;
    logic            w_stall;

    assign w_d_payload = {d_opcode, d_reg1_data, d_reg2_data, d_immediate,
                          d_vec1_data, d_vec2_data, d_wb_register};

    // Handshake qualifiers; rst_n gating keeps d_ready low throughout reset
    assign w_d_ready  = rst_n & en & (r_state != SKID);
    assign w_q_valid  = en & (r_state != EMPTY);
    assign w_accept   = d_valid & w_d_ready;
    assign w_transfer = w_q_valid & q_ready;
    assign w_stall    = w_q_valid & ~q_ready & ~flush;

    assign d_ready   = w_d_ready;
    assign q_valid   = w_q_valid;
    assign occupancy = 2'(r_state);
    assign stall_cnt = r_stall_cnt;
    assign {q_opcode, q_reg1_data, q_reg2_data, q_immediate,
            q_vec1_data, q_vec2_data, q_wb_register} = r_main;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and payload load selects; flush wins over everything, en=0 freezes
    always_comb begin
        w_next_state   = r_state;
        w_ld_main_d    = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_next_state = EMPTY;
        end else if (en) begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_ld_main_d  = 1'b1;
                        w_next_state = FULL;
                    end
                end
                FULL: begin
                    if (w_accept && w_transfer) begin
                        w_ld_main_d = 1'b1;
                    end else if (w_accept) begin
                        w_ld_skid    = 1'b1;
                        w_next_state = SKID;
                    end else if (w_transfer) begin
                        w_next_state = EMPTY;
                    end
                end
                SKID: begin
                    if (w_transfer) begin
                        w_ld_main_skid = 1'b1;
                        w_next_state   = FULL;
                    end
                end
                default: begin
                    w_next_state = EMPTY;
                end
            endcase
        end
    end

    // Main register: new entry from upstream or promoted from the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main <= '0;
        end else if (w_ld_main_d) begin
            r_main <= w_d_payload;
        end else if (w_ld_main_skid) begin
            r_main <= r_skid;
        end
    end

    // Skid register: catches the entry accepted while main is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid <= '0;
        end else if (w_ld_skid) begin
            r_skid <= w_d_payload;
        end
    end

    // Saturating back-pressure counter, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_exec_reg.sv
// Bench for pipe_exec_reg: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_exec_reg;

    localparam int unsigned OP_W     = 5;
    localparam int unsigned SCALAR_W = 32;
    localparam int unsigned IMM_W    = 8;
    localparam int unsigned VEC_W    = 128;
    localparam int unsigned WB_W     = 3;
    localparam int unsigned PL_W     = OP_W + 2 * SCALAR_W + IMM_W + 2 * VEC_W + WB_W;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en, flush, d_valid, q_ready;
    logic                d_ready, q_valid;
    logic [OP_W-1:0]     d_opcode, q_opcode;
    logic [SCALAR_W-1:0] d_reg1_data, d_reg2_data, q_reg1_data, q_reg2_data;
    logic [IMM_W-1:0]    d_immediate, q_immediate;
    logic [VEC_W-1:0]    d_vec1_data, d_vec2_data, q_vec1_data, q_vec2_data;
    logic [WB_W-1:0]     d_wb_register, q_wb_register;
    logic [1:0]          occupancy;
    logic [15:0]         stall_cnt;

    int n_err = 0;
    int n_chk = 0;

    pipe_exec_reg #(
        .OP_W(OP_W), .SCALAR_W(SCALAR_W), .IMM_W(IMM_W), .VEC_W(VEC_W), .WB_W(WB_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .flush(flush),
        .d_valid(d_valid), .d_ready(d_ready),
        .d_opcode(d_opcode), .d_reg1_data(d_reg1_data), .d_reg2_data(d_reg2_data),
        .d_immediate(d_immediate), .d_vec1_data(d_vec1_data), .d_vec2_data(d_vec2_data),
        .d_wb_register(d_wb_register),
        .q_valid(q_valid), .q_ready(q_ready),
        .q_opcode(q_opcode), .q_reg1_data(q_reg1_data), .q_reg2_data(q_reg2_data),
        .q_immediate(q_immediate), .q_vec1_data(q_vec1_data), .q_vec2_data(q_vec2_data),
        .q_wb_register(q_wb_register),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    wire [PL_W-1:0] d_pl = {d_opcode, d_reg1_data, d_reg2_data, d_immediate,
                            d_vec1_data, d_vec2_data, d_wb_register};
    wire [PL_W-1:0] q_pl = {q_opcode, q_reg1_data, q_reg2_data, q_immediate,
                            q_vec1_data, q_vec2_data, q_wb_register};

    // Reference model: an ordered list of held entries, at most two
    logic [PL_W-1:0] mq[$];
    logic [PL_W-1:0] m_shown = '0;
    logic [15:0]     m_stall = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_shown = '0;
            m_stall = '0;
        end else begin
            bit acc, xfer;
            acc  = en && d_valid && (mq.size() < 2);
            xfer = en && (mq.size() > 0) && q_ready;
            if (en && (mq.size() > 0) && !q_ready && !flush && (m_stall != 16'hFFFF))
                m_stall = m_stall + 16'd1;
            if (flush) begin
                mq.delete();
            end else begin
                if (xfer) void'(mq.pop_front());
                if (acc) mq.push_back(d_pl);
            end
            if (mq.size() > 0) m_shown = mq[0];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, mid-cycle when everything is settled
    always @(negedge clk) begin
        chk("q_valid", 64'(q_valid), 64'(en && (mq.size() > 0)));
        chk("d_ready", 64'(d_ready), 64'(rst_n && en && (mq.size() < 2)));
        chk("occupancy", 64'(occupancy), 64'(mq.size()));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
        n_chk++;
        if (q_pl !== m_shown) begin
            n_err++;
            $display("FAIL payload: got %h expected %h at %0t", q_pl, m_shown, $time);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic put(input logic [OP_W-1:0] op, input logic [SCALAR_W-1:0] r1,
                       input logic [SCALAR_W-1:0] r2, input logic [IMM_W-1:0] imm,
                       input logic [VEC_W-1:0] v1, input logic [VEC_W-1:0] v2,
                       input logic [WB_W-1:0] wb);
        d_opcode = op; d_reg1_data = r1; d_reg2_data = r2; d_immediate = imm;
        d_vec1_data = v1; d_vec2_data = v2; d_wb_register = wb;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; d_valid = 1'b0; q_ready = 1'b1;
        put(0, 0, 0, 0, 0, 0, 0);

        // Reset state: d_ready forced low even with en=1
        cyc(3);
        chk("rst_d_ready", 64'(d_ready), 64'd0);
        chk("rst_q_valid", 64'(q_valid), 64'd0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_stall", 64'(stall_cnt), 64'd0);
        rst_n = 1'b1;
        cyc(1);

        // Single entry, one-cycle latency
        d_valid = 1'b1; put(8, 5, 15, 8, 32, 90, 3);
        cyc(1);
        chk("a_q_valid", 64'(q_valid), 64'd1);
        chk("a_opcode", 64'(q_opcode), 64'd8);
        chk("a_reg1", 64'(q_reg1_data), 64'd5);
        chk("a_reg2", 64'(q_reg2_data), 64'd15);
        chk("a_imm", 64'(q_immediate), 64'd8);
        chk("a_vec1", 64'(q_vec1_data), 64'd32);
        chk("a_vec2", 64'(q_vec2_data), 64'd90);
        chk("a_wb", 64'(q_wb_register), 64'd3);
        chk("a_occ", 64'(occupancy), 64'd1);
        d_valid = 1'b0; q_ready = 1'b0;

        // Second entry goes to skid, then both drain in order
        d_valid = 1'b1; put(12, 7, 1, 2, 3, 4, 5);
        cyc(1);
        chk("b_occ", 64'(occupancy), 64'd2);
        chk("b_d_ready", 64'(d_ready), 64'd0);
        chk("b_opcode", 64'(q_opcode), 64'd8);
        d_valid = 1'b0; q_ready = 1'b1;
        cyc(1);
        chk("b_drain1_opcode", 64'(q_opcode), 64'd12);
        chk("b_drain1_reg1", 64'(q_reg1_data), 64'd7);
        chk("b_drain1_occ", 64'(occupancy), 64'd1);
        cyc(1);
        chk("b_drain2_occ", 64'(occupancy), 64'd0);
        chk("b_drain2_q_valid", 64'(q_valid), 64'd0);

        // Back-to-back streaming: accept and transfer in the same cycle
        d_valid = 1'b1; put(3, 30, 31, 32, 33, 34, 1);
        cyc(1);
        put(4, 40, 41, 42, 43, 44, 2);
        cyc(1);
        chk("c_opcode", 64'(q_opcode), 64'd4);
        chk("c_occ", 64'(occupancy), 64'd1);
        d_valid = 1'b0; q_ready = 1'b0;

        // Freeze with en=0 while new data is offered
        en = 1'b0; d_valid = 1'b1; put(20, 99, 98, 97, 96, 95, 6);
        cyc(5);
        chk("f_q_valid", 64'(q_valid), 64'd0);
        chk("f_d_ready", 64'(d_ready), 64'd0);
        chk("f_opcode", 64'(q_opcode), 64'd4);
        chk("f_stall", 64'(stall_cnt), 64'd1);
        en = 1'b1; d_valid = 1'b0;
        #1;
        chk("f_resume_q_valid", 64'(q_valid), 64'd1);
        chk("f_resume_opcode", 64'(q_opcode), 64'd4);

        // Flush at occupancy 2, with a concurrent accept that must be dropped
        d_valid = 1'b1; put(6, 60, 61, 62, 63, 64, 0);
        cyc(1);
        chk("g_occ", 64'(occupancy), 64'd2);
        flush = 1'b1; put(7, 70, 71, 72, 73, 74, 7);
        cyc(1);
        chk("g_flush_occ", 64'(occupancy), 64'd0);
        chk("g_flush_q_valid", 64'(q_valid), 64'd0);
        chk("g_flush_d_ready", 64'(d_ready), 64'd1);
        chk("g_flush_opcode", 64'(q_opcode), 64'd4);
        chk("g_flush_stall", 64'(stall_cnt), 64'd2);
        flush = 1'b0; d_valid = 1'b0; q_ready = 1'b1;
        cyc(2);
        chk("g_after_occ", 64'(occupancy), 64'd0);

        // Asynchronous reset between edges at occupancy 2
        q_ready = 1'b0; d_valid = 1'b1; put(9, 1, 1, 1, 1, 1, 1);
        cyc(1);
        put(10, 2, 2, 2, 2, 2, 2);
        cyc(1);
        d_valid = 1'b0;
        chk("h_occ", 64'(occupancy), 64'd2);
        chk("h_stall", 64'(stall_cnt), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        chk("h_rst_q_valid", 64'(q_valid), 64'd0);
        chk("h_rst_d_ready", 64'(d_ready), 64'd0);
        chk("h_rst_opcode", 64'(q_opcode), 64'd0);
        chk("h_rst_vec1", 64'(q_vec1_data[63:0]), 64'd0);
        chk("h_rst_occ", 64'(occupancy), 64'd0);
        chk("h_rst_stall", 64'(stall_cnt), 64'd0);
        cyc(1);
        rst_n = 1'b1;
        d_valid = 1'b1; q_ready = 1'b1; put(8, 5, 15, 8, 32, 90, 3);
        cyc(1);
        chk("h_first_occ", 64'(occupancy), 64'd1);
        chk("h_first_opcode", 64'(q_opcode), 64'd8);
        d_valid = 1'b0; q_ready = 1'b0;

        // Long stall saturates the counter
        cyc(70000);
        chk("s_sat", 64'(stall_cnt), 64'hFFFF);
        cyc(3);
        chk("s_hold", 64'(stall_cnt), 64'hFFFF);
        q_ready = 1'b1;
        cyc(2);
        chk("s_drained_occ", 64'(occupancy), 64'd0);
        chk("s_after_drain", 64'(stall_cnt), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
